// File: rtl/vga_pkg.sv
// Shared constants for the VGA code feeder: opcodes, 800x600@72 frame geometry
// and the controller state encoding.
package vga_pkg;

    localparam int H_TOTAL      = 1040;
    localparam int V_TOTAL      = 666;
    localparam int FRAME_CYCLES = H_TOTAL * V_TOTAL;

    localparam logic [1:0] OP_SET_L  = 2'b00;
    localparam logic [1:0] OP_SET_R  = 2'b01;
    localparam logic [1:0] OP_COMMIT = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic {
        IDLE       = 1'b0,
        WAIT_FRAME = 1'b1
    } state_t;

endpackage

// File: rtl/vga_frame_timer.sv
// Free-running frame position counter, reset-aligned with the VGA stage;
// frame_tick marks the apply-point cycle (frame_cnt == FRAME_CYCLES-2).
module vga_frame_timer #(
    parameter int FRAME_CYCLES = vga_pkg::FRAME_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [19:0] frame_cnt,
    output logic        frame_tick
);

    localparam logic [19:0] LAST_CNT  = 20'(FRAME_CYCLES - 1);
    localparam logic [19:0] APPLY_CNT = 20'(FRAME_CYCLES - 2);

    logic [19:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST_CNT) ? 20'd0 : cnt_q + 20'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 20'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign frame_cnt  = cnt_q;
    assign frame_tick = (cnt_q == APPLY_CNT);

endmodule

// File: rtl/vga_code_ctrl.sv
// Stages left/right RGB444 colours from CPU commands and commits them to the
// VGA code bus atomically at the frame apply point. Optional blink: VGA_CODE_BLINK_EN.
module vga_code_ctrl
    import vga_pkg::*;
#(
    parameter int FRAME_CYCLES = vga_pkg::FRAME_CYCLES,
    parameter int BLINK_FRAMES = 36
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic [23:0] code,
    output logic        busy,
    output logic        frame_tick
);

    logic [19:0] frame_cnt;
    logic        accept;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic [11:0] stage_l_q, stage_l_d;
    logic [11:0] stage_r_q, stage_r_d;
    logic [23:0] code_q, code_d;

`ifdef VGA_CODE_BLINK_EN
    localparam int GW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [23:0]   committed_q, committed_d;
    logic          blink_req_q, blink_req_d;
    logic          blink_on_q, blink_on_d;
    logic          blink_phase_q, blink_phase_d;
    logic [GW-1:0] grp_q, grp_d;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
`endif

    logic unused_bits;
    assign unused_bits = ^{cmd_data[13:12], frame_cnt};

    vga_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_cnt  (frame_cnt),
        .frame_tick (frame_tick)
    );

    assign accept = cmd_valid && cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        stage_l_d   = stage_l_q;
        stage_r_d   = stage_r_q;
        code_d      = code_q;
`ifdef VGA_CODE_BLINK_EN
        committed_d   = committed_q;
        blink_req_d   = blink_req_q;
        blink_on_d    = blink_on_q;
        blink_phase_d = blink_phase_q;
        grp_d         = grp_q;
`endif
        case (state_q)
            IDLE: begin
                // A COMMIT taken on the apply edge itself waits a full frame,
                // since the WAIT_FRAME branch only sees frame_tick from the next cycle on.
                if (accept) begin
                    case (cmd_data[15:14])
                        OP_SET_L: stage_l_d = cmd_data[11:0];
                        OP_SET_R: stage_r_d = cmd_data[11:0];
                        OP_CLEAR: begin
                            stage_l_d = 12'd0;
                            stage_r_d = 12'd0;
                        end
                        OP_COMMIT: begin
                            state_d     = WAIT_FRAME;
                            cmd_ready_d = 1'b0;
                            busy_d      = 1'b1;
`ifdef VGA_CODE_BLINK_EN
                            blink_req_d = cmd_data[13];
`endif
                        end
                    endcase
                end
            end
            WAIT_FRAME: begin
                if (frame_tick) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
`ifdef VGA_CODE_BLINK_EN
                    committed_d = {stage_l_q, stage_r_q};
                    blink_on_d  = blink_req_q;
`else
                    code_d      = {stage_l_q, stage_r_q};
`endif
                end
            end
        endcase
`ifdef VGA_CODE_BLINK_EN
        if (frame_tick) begin
            if (grp_q == GW'(BLINK_FRAMES - 1)) begin
                grp_d         = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                grp_d = grp_q + 1'b1;
            end
        end
        // Blanking is folded into the output register; the colour itself survives.
        code_d = (blink_on_d && blink_phase_d) ? 24'd0 : committed_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            stage_l_q   <= 12'd0;
            stage_r_q   <= 12'd0;
            code_q      <= 24'd0;
`ifdef VGA_CODE_BLINK_EN
            committed_q   <= 24'd0;
            blink_req_q   <= 1'b0;
            blink_on_q    <= 1'b0;
            blink_phase_q <= 1'b0;
            grp_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            stage_l_q   <= stage_l_d;
            stage_r_q   <= stage_r_d;
            code_q      <= code_d;
`ifdef VGA_CODE_BLINK_EN
            committed_q   <= committed_d;
            blink_req_q   <= blink_req_d;
            blink_on_q    <= blink_on_d;
            blink_phase_q <= blink_phase_d;
            grp_q         <= grp_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign code      = code_q;

endmodule
